alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, handshaked successor to the single-cycle ALU. Takes the existing operand pair (read1, foutput) and the 6-bit control code.
- Single-cycle ops: add, sub, and, or, nor, slt. Adds iterative unsigned multiply and divide, plus a HI result register.
- Result and overflow are registered. Sits between the register-file read stage and the writeback mux; the pipeline stalls on in_ready/out_valid.

Parameters:
- WIDTH, 32: operand and result width in bits (>=4).
- CTRL_W, 6: control code width.
- CNT_W, $clog2(WIDTH)+1: iteration counter width. Derived; do not override.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands and control are valid
- in_ready  output  1  block can accept an operation
- control  input  CTRL_W  operation code
- read1  input  WIDTH  operand A
- foutput  input  WIDTH  operand B
- out_valid  output  1  oc/hi/overflow hold a result
- out_ready  input  1  consumer takes the result
- oc  output  WIDTH  primary result
- hi  output  WIDTH  multiply high half / divide remainder
- overflow  output  1  status flag for the result

Behaviour:
- Reset (asynchronous on reset_n low):
  - State goes to IDLE.
  - oc=0, hi=0, overflow=0, out_valid=0, in_ready=1.
  - The counter and operand/accumulator registers are cleared.
  - Reset asserted mid-operation aborts the operation and produces no output.
- Handshake:
  - An operation is accepted on a rising edge with in_valid & in_ready.
  - in_ready = (state==IDLE). Only one operation is outstanding at a time.
  - out_valid stays high, with oc/hi/overflow stable, until the edge where out_ready=1. The block then returns to IDLE, and in_ready=1 on the next cycle.
  - in_valid while in_ready=0 is ignored.
- States: IDLE, MUL, DIV, DONE.
- Control codes and results:
  - 16 add: oc = A+B mod 2^WIDTH; overflow = carry-out. IDLE->DONE.
  - 34 sub: oc = A-B; overflow = borrow (A<B unsigned). IDLE->DONE.
  - 36 and, 35 or, 39 nor: bitwise; overflow=0. IDLE->DONE.
  - 42 slt: oc = 1 if A<B unsigned, else 0; overflow=0. IDLE->DONE.
  - 24 multu: shift-add, one bit per cycle, WIDTH cycles in MUL.
    - {hi,oc} = A*B.
    - overflow = (hi!=0).
  - 27 divu: restoring division, one bit per cycle, WIDTH cycles in DIV.
    - oc = quotient, hi = remainder, overflow=0.
    - If B==0: IDLE->DONE directly; oc = all ones, hi = A, overflow=1.
  - Any other code: oc=1, hi unchanged, overflow=0, IDLE->DONE.
  - For all codes except 24 and 27, hi holds its previous value.
- Latency, with acceptance edge = N:
  - Single-cycle ops and div-by-zero: out_valid high after edge N+1.
  - multu/divu: out_valid high after edge N+WIDTH+1.
- Counter:
  - Loads WIDTH-1 on entry to MUL/DIV and decrements each cycle.
  - Transitions to DONE on the cycle it reads 0. No wrap-around is possible.
- Operands are captured at acceptance. Later changes on read1/foutput/control do not affect an in-flight operation.
- out_ready while in MUL/DIV is ignored.

Optional Feature:
- Macro: ALU_SIGNED_SLT_EN.
- Defined:
  - Code 42 compares A and B as two's-complement signed values.
  - Code 16 overflow becomes signed overflow: operand signs equal and result sign differs.
  - Code 34 overflow becomes signed overflow: operand signs differ and result sign differs from A.
- Undefined: unsigned semantics as listed in Behaviour.
- multu/divu are unaffected either way.

Test Plan:
- WIDTH=32: add A=0xFFFFFFFF, B=0x00000001 -> after 1 cycle: out_valid=1, oc=0x00000000, overflow=1. With ALU_SIGNED_SLT_EN: overflow=0.
- slt A=0xFFFFFFFE, B=0x00000001 -> oc=0 (unsigned). With ALU_SIGNED_SLT_EN: oc=1.
- multu A=0x00010000, B=0x00030000 -> out_valid exactly 33 cycles after acceptance. Result hi=0x00000003, oc=0, overflow=1. in_ready=0 throughout.
- divu A=100, B=7 -> after 33 cycles: oc=14, hi=2, overflow=0. divu A=5, B=0 -> after 1 cycle: oc=0xFFFFFFFF, hi=5, overflow=1.
- Backpressure: hold out_ready=0 for 5 cycles after an and of A=0xF0F0, B=0xFF00.
  - oc=0xF000 stays stable and in_ready=0 during the stall.
  - A second in_valid during the stall is ignored.
  - After out_ready=1: in_ready=1 on the next cycle.
- Drop reset_n low mid-multu (cycle 10) -> outputs immediately go to 0, in_ready=1. After release, a new add 2+3 gives oc=5.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with single-cycle logic/arith ops, iterative multu/divu and a HI register.
// Latency: single-cycle ops and div-by-zero 1 cycle after acceptance; multu/divu WIDTH+1 cycles.
// Backpressure: in_ready only in IDLE; result held stable with out_valid until out_ready.
// Optional macro ALU_SIGNED_SLT_EN: signed slt and signed add/sub overflow.
module alu_seq #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 6
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] control,
  input  logic [WIDTH-1:0]  read1,
  input  logic [WIDTH-1:0]  foutput,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  oc,
  output logic [WIDTH-1:0]  hi,
  output logic              overflow
);

  // Counter width is derived from WIDTH and must not be overridden.
  localparam int CNT_W = $clog2(WIDTH) + 1;

  localparam logic [CTRL_W-1:0] OP_ADD   = CTRL_W'(16);
  localparam logic [CTRL_W-1:0] OP_SUB   = CTRL_W'(34);
  localparam logic [CTRL_W-1:0] OP_AND   = CTRL_W'(36);
  localparam logic [CTRL_W-1:0] OP_OR    = CTRL_W'(35);
  localparam logic [CTRL_W-1:0] OP_NOR   = CTRL_W'(39);
  localparam logic [CTRL_W-1:0] OP_SLT   = CTRL_W'(42);
  localparam logic [CTRL_W-1:0] OP_MULTU = CTRL_W'(24);
  localparam logic [CTRL_W-1:0] OP_DIVU  = CTRL_W'(27);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CTRL_W-1:0]  op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;   // product high half / partial remainder
  logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;   // multiplier bits / dividend-quotient shifter
  logic [WIDTH-1:0]   oc_q, oc_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic               ovf_q, ovf_d;
  logic               out_valid_q, out_valid_d;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   div_trial;
  logic [WIDTH-1:0]   res_oc;
  logic [WIDTH-1:0]   res_hi;
  logic               res_ovf;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign oc        = oc_q;
  assign hi        = hi_q;
  assign overflow  = ovf_q;

  // One shift-add multiply step and one restoring-division step from the accumulators.
  always_comb begin
    mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
    div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, b_q});
    // When div_ge holds the true difference is below b_q, so it fits in WIDTH bits.
    div_trial = div_shift[WIDTH-1:0] - b_q;
  end

  // Final result selection from the captured operation, evaluated in DONE.
`ifdef ALU_SIGNED_SLT_EN
  logic [WIDTH-1:0] add_res;
  assign add_res = a_q + b_q;
`else
  logic [WIDTH:0]   add_res;
  assign add_res = {1'b0, a_q} + {1'b0, b_q};
`endif
  logic [WIDTH-1:0] sub_res;
  assign sub_res = a_q - b_q;

  always_comb begin
    res_oc  = {{(WIDTH-1){1'b0}}, 1'b1};
    res_hi  = hi_q;
    res_ovf = 1'b0;
    case (op_q)
      OP_ADD: begin
        res_oc  = add_res[WIDTH-1:0];
`ifdef ALU_SIGNED_SLT_EN
        res_ovf = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_res[WIDTH-1] != a_q[WIDTH-1]);
`else
        res_ovf = add_res[WIDTH];
`endif
      end
      OP_SUB: begin
        res_oc  = sub_res;
`ifdef ALU_SIGNED_SLT_EN
        res_ovf = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sub_res[WIDTH-1] != a_q[WIDTH-1]);
`else
        res_ovf = (a_q < b_q);
`endif
      end
      OP_AND: res_oc = a_q & b_q;
      OP_OR:  res_oc = a_q | b_q;
      OP_NOR: res_oc = ~(a_q | b_q);
      OP_SLT: begin
`ifdef ALU_SIGNED_SLT_EN
        res_oc = {{(WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
`else
        res_oc = {{(WIDTH-1){1'b0}}, (a_q < b_q)};
`endif
      end
      OP_MULTU: begin
        res_oc  = acc_lo_q;
        res_hi  = acc_hi_q;
        res_ovf = |acc_hi_q;
      end
      OP_DIVU: begin
        if (b_q == '0) begin
          res_oc  = '1;
          res_hi  = a_q;
          res_ovf = 1'b1;
        end else begin
          res_oc  = acc_lo_q;
          res_hi  = acc_hi_q;
        end
      end
      default: ;
    endcase
  end

  // Next-state, iteration and output-register update logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_hi_d    = acc_hi_q;
    acc_lo_d    = acc_lo_q;
    oc_d        = oc_q;
    hi_d        = hi_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d     = control;
          a_d      = read1;
          b_d      = foutput;
          acc_hi_d = '0;
          acc_lo_d = (control == OP_DIVU) ? read1 : foutput;
          cnt_d    = CNT_W'(WIDTH - 1);
          if (control == OP_MULTU) begin
            state_d = MUL;
          end else if (control == OP_DIVU && foutput != '0) begin
            state_d = DIV;
          end else begin
            state_d = DONE;
          end
        end
      end
      MUL: begin
        acc_hi_d = mul_sum[WIDTH:1];
        acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
        if (cnt_q == '0) state_d = DONE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      DIV: begin
        acc_hi_d = div_ge ? div_trial : div_shift[WIDTH-1:0];
        acc_lo_d = {acc_lo_q[WIDTH-2:0], div_ge};
        if (cnt_q == '0) state_d = DONE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      DONE: begin
        // First DONE cycle registers the result; it is then held until taken.
        if (!out_valid_q) begin
          oc_d        = res_oc;
          hi_d        = res_hi;
          ovf_d       = res_ovf;
          out_valid_d = 1'b1;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any in-flight operation.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      acc_hi_q    <= '0;
      acc_lo_q    <= '0;
      oc_q        <= '0;
      hi_q        <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_hi_q    <= acc_hi_d;
      acc_lo_q    <= acc_lo_d;
      oc_q        <= oc_d;
      hi_q        <= hi_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Testbench for alu_seq (WIDTH=32): directed vector table plus handshake, backpressure and reset sequences.
module tb_alu_seq;

  localparam int W = 32;

`ifdef ALU_SIGNED_SLT_EN
  localparam bit SGN = 1'b1;
`else
  localparam bit SGN = 1'b0;
`endif

  logic          clk;
  logic          reset_n;
  logic          in_valid;
  logic          in_ready;
  logic [5:0]    control;
  logic [W-1:0]  read1;
  logic [W-1:0]  foutput;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  oc;
  logic [W-1:0]  hi;
  logic          overflow;

  int checks = 0;
  int errors = 0;

  alu_seq #(.WIDTH(W), .CTRL_W(6)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .control   (control),
    .read1     (read1),
    .foutput   (foutput),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .oc        (oc),
    .hi        (hi),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]   ctrl;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] e_oc;
    logic [W-1:0] e_hi;
    logic         e_ovf;
    int           e_lat;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Issue one operation, wait for out_valid, return the latency in cycles.
  task automatic issue_wait(input logic [5:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                            output int lat, output bit rdy_low);
    @(negedge clk);
    chk("in_ready_before_issue", 64'(in_ready), 64'd1);
    control  = c;
    read1    = a;
    foutput  = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    // Scramble operands to confirm they were captured at acceptance.
    control  = 6'd16;
    read1    = 32'hDEAD_BEEF;
    foutput  = 32'h1234_5678;
    lat      = 0;
    rdy_low  = 1'b1;
    while (!out_valid && lat < 100) begin
      if (in_ready) rdy_low = 1'b0;
      @(posedge clk);
      #1;
      lat++;
    end
    if (lat >= 100) begin
      errors++;
      checks++;
      $display("FAIL timeout_out_valid actual=%0d expected=<100", lat);
    end
  endtask

  // Complete the result handshake and confirm the block is ready again.
  task automatic take_result();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("in_ready_after_take", 64'(in_ready), 64'd1);
    chk("out_valid_after_take", 64'(out_valid), 64'd0);
  endtask

  vec_t vecs[17];

  initial begin
    int lat;
    bit rdy_low;
    logic [W-1:0] held;

    vecs[0]  = '{6'd16, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'h0, SGN ? 1'b0 : 1'b1, 1};
    vecs[1]  = '{6'd16, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 32'h0, SGN ? 1'b1 : 1'b0, 1};
    vecs[2]  = '{6'd34, 32'd5,         32'd3,         32'd2,         32'h0, 1'b0, 1};
    vecs[3]  = '{6'd34, 32'd3,         32'd5,         32'hFFFF_FFFE, 32'h0, SGN ? 1'b0 : 1'b1, 1};
    vecs[4]  = '{6'd36, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 32'h0, 1'b0, 1};
    vecs[5]  = '{6'd35, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0, 32'h0, 1'b0, 1};
    vecs[6]  = '{6'd39, 32'h0000_F0F0, 32'h0000_FF00, 32'hFFFF_000F, 32'h0, 1'b0, 1};
    vecs[7]  = '{6'd42, 32'hFFFF_FFFE, 32'h0000_0001, SGN ? 32'd1 : 32'd0, 32'h0, 1'b0, 1};
    vecs[8]  = '{6'd42, 32'd1,         32'd2,         32'd1,         32'h0, 1'b0, 1};
    vecs[9]  = '{6'd24, 32'h0001_0000, 32'h0003_0000, 32'h0000_0000, 32'h3, 1'b1, 33};
    vecs[10] = '{6'd16, 32'd2,         32'd3,         32'd5,         32'h3, 1'b0, 1};
    vecs[11] = '{6'd24, 32'd1234,      32'd10,        32'd12340,     32'h0, 1'b0, 33};
    vecs[12] = '{6'd27, 32'd100,       32'd7,         32'd14,        32'd2, 1'b0, 33};
    vecs[13] = '{6'd27, 32'd5,         32'd0,         32'hFFFF_FFFF, 32'd5, 1'b1, 1};
    vecs[14] = '{6'd0,  32'd77,        32'd88,        32'd1,         32'd5, 1'b0, 1};
    vecs[15] = '{6'd24, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 1'b1, 33};
    vecs[16] = '{6'd27, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 32'h0, 1'b0, 33};

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    control   = '0;
    read1     = '0;
    foutput   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_oc", 64'(oc), 64'd0);
    chk("reset_hi", 64'(hi), 64'd0);
    chk("reset_ovf", 64'(overflow), 64'd0);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    reset_n = 1'b1;

    // Directed vector table.
    for (int i = 0; i < 17; i++) begin
      issue_wait(vecs[i].ctrl, vecs[i].a, vecs[i].b, lat, rdy_low);
      chk($sformatf("v%0d_lat", i), 64'(lat), 64'(vecs[i].e_lat));
      chk($sformatf("v%0d_oc", i), 64'(oc), 64'(vecs[i].e_oc));
      chk($sformatf("v%0d_hi", i), 64'(hi), 64'(vecs[i].e_hi));
      chk($sformatf("v%0d_ovf", i), 64'(overflow), 64'(vecs[i].e_ovf));
      if (vecs[i].e_lat > 1) chk($sformatf("v%0d_in_ready_busy", i), 64'(rdy_low), 64'd1);
      take_result();
    end

    // Backpressure: result held for 5 cycles while a second request is presented.
    issue_wait(6'd36, 32'h0000_F0F0, 32'h0000_FF00, lat, rdy_low);
    chk("bp_lat", 64'(lat), 64'd1);
    held = oc;
    chk("bp_oc", 64'(held), 64'h0000_F000);
    @(negedge clk);
    control  = 6'd16;
    read1    = 32'd40;
    foutput  = 32'd2;
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("bp_stall%0d_oc", k), 64'(oc), 64'h0000_F000);
      chk($sformatf("bp_stall%0d_in_ready", k), 64'(in_ready), 64'd0);
      chk($sformatf("bp_stall%0d_out_valid", k), 64'(out_valid), 64'd1);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("bp_in_ready_after", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    chk("bp_ignored_req_no_result", 64'(out_valid), 64'd0);
    chk("bp_ignored_req_idle", 64'(in_ready), 64'd1);
    chk("bp_oc_unchanged", 64'(oc), 64'h0000_F000);

    // Reset during multu aborts the operation.
    @(negedge clk);
    control  = 6'd24;
    read1    = 32'h0001_0000;
    foutput  = 32'h0003_0000;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("mid_mul_busy", 64'(in_ready), 64'd0);
    reset_n = 1'b0;
    #1;
    chk("rst_mid_oc", 64'(oc), 64'd0);
    chk("rst_mid_hi", 64'(hi), 64'd0);
    chk("rst_mid_ovf", 64'(overflow), 64'd0);
    chk("rst_mid_out_valid", 64'(out_valid), 64'd0);
    chk("rst_mid_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    reset_n = 1'b1;
    issue_wait(6'd16, 32'd2, 32'd3, lat, rdy_low);
    chk("post_rst_lat", 64'(lat), 64'd1);
    chk("post_rst_oc", 64'(oc), 64'd5);
    chk("post_rst_hi", 64'(hi), 64'd0);
    chk("post_rst_ovf", 64'(overflow), 64'd0);
    take_result();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
